// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
// Shared types for the AXI4-Lite register slave: bus word types, the response
// encoding, the write/read channel state enums and a small width helper.
// No ports (package).
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef logic [AXI_ADDR_W-1:0] addr_t;
  typedef logic [AXI_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Write channel: the address and the data may arrive in either order, so
  // each half can be latched while waiting for the other.
  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wfsm_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rfsm_t;

  // Index width for a register file of n entries; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if
// AXI4-Lite bundle without clock/reset (those stay plain module ports).
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
// Modports: master drives the requests, slave drives readies and responses.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// axi_lite_addr_decode
// Combinational byte-address to register-index decoder.
// Ports:
//   addr in  ADDR_WIDTH : byte address from AW or AR
//   idx  out IDX_W      : word index relative to BASE_ADDR
//   hit  out 1          : address is word aligned and inside the register file
module axi_lite_addr_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  assign offset = addr - BASE_ADDR;
  assign word   = offset >> 2;
  assign idx    = word[IDX_W-1:0];

  // The full-width word compare matters: idx alone is truncated and would
  // alias out-of-range addresses onto real registers.
  assign hit = (addr[1:0] == 2'b00) &&
               (addr >= BASE_ADDR) &&
               (word < ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
// AXI4-Lite responder with a NUM_REGS x 32-bit register file, byte strobes and
// OKAY/SLVERR responses. Write and read channels run independently, each with
// one outstanding transaction.
// Ports:
//   clk  in  1 : clock, rising edge
//   rst  in  1 : synchronous active-high reset
//   bus  slave modport of axi_lite_if (AW, W, B, AR, R channels)
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic       clk,
  input logic       rst,
  axi_lite_if.slave bus
);

  localparam int IDX_W     = idx_width(NUM_REGS);
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // ---------------------------------------------------------------- write side
  wfsm_t                   wstate_reg, wstate_next;
  logic                    awready_reg, awready_next;
  logic                    wready_reg, wready_next;
  logic                    bvalid_reg, bvalid_next;
  resp_t                   bresp_reg, bresp_next;
  logic [ADDR_WIDTH-1:0]   aw_addr_reg, aw_addr_next;
  logic [DATA_WIDTH-1:0]   w_data_reg, w_data_next;
  logic [NUM_BYTES-1:0]    w_strb_reg, w_strb_next;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_BYTES-1:0]    wr_strb;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_hit;

  // ----------------------------------------------------------------- read side
  rfsm_t                   rstate_reg, rstate_next;
  logic                    arready_reg, arready_next;
  logic                    rvalid_reg, rvalid_next;
  resp_t                   rresp_reg, rresp_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;

  logic                    ar_hs;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_hit;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign aw_hs = bus.awvalid && awready_reg;
  assign w_hs  = bus.wvalid && wready_reg;
  assign ar_hs = bus.arvalid && arready_reg;

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_aw_decode (
    .addr (wr_addr),
    .idx  (wr_idx),
    .hit  (wr_hit)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_ar_decode (
    .addr (bus.araddr),
    .idx  (rd_idx),
    .hit  (rd_hit)
  );

  // Write FSM: next state, latched halves and the commit strobe.
  // wr_addr/wr_data/wr_strb select between the live bus and the latched copy,
  // so the commit sees a complete request on the edge that enters W_RESP.
  always_comb begin
    wstate_next  = wstate_reg;
    aw_addr_next = aw_addr_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    bresp_next   = bresp_reg;
    commit       = 1'b0;
    wr_addr      = aw_addr_reg;
    wr_data      = w_data_reg;
    wr_strb      = w_strb_reg;

    case (wstate_reg)
      W_IDLE: begin
        wr_addr = bus.awaddr;
        wr_data = bus.wdata;
        wr_strb = bus.wstrb;
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end else if (aw_hs) begin
          aw_addr_next = bus.awaddr;
          wstate_next  = W_WAIT_DATA;
        end else if (w_hs) begin
          w_data_next = bus.wdata;
          w_strb_next = bus.wstrb;
          wstate_next = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        wr_data = bus.wdata;
        wr_strb = bus.wstrb;
        if (w_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        wr_addr = bus.awaddr;
        if (aw_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          wstate_next = W_IDLE;
        end
      end
      default: wstate_next = W_IDLE;
    endcase

    if (commit) begin
      bresp_next = wr_hit ? OKAY : SLVERR;
    end

    // Readies are registered from the state being entered, so each channel
    // half is offered exactly while the FSM still needs it.
    awready_next = (wstate_next == W_IDLE) || (wstate_next == W_WAIT_ADDR);
    wready_next  = (wstate_next == W_IDLE) || (wstate_next == W_WAIT_DATA);
    bvalid_next  = (wstate_next == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_reg  <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= OKAY;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      wstate_reg  <= wstate_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      aw_addr_reg <= aw_addr_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
    end
  end

  // Register file, one byte lane per generate iteration so each strobe bit
  // owns its own storage.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] mem [NUM_REGS];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
          end
        end else if (commit && wr_hit && wr_strb[gi]) begin
          mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = mem[rd_idx];
    end
  endgenerate

  // Read FSM. rd_word is sampled on the AR edge before any same-edge write
  // lands, so a colliding read returns the pre-write value.
  always_comb begin
    rstate_next = rstate_reg;
    rdata_next  = rdata_reg;
    rresp_next  = rresp_reg;

    case (rstate_reg)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_next  = rd_hit ? rd_word : '0;
          rresp_next  = rd_hit ? OKAY : SLVERR;
          rstate_next = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          rstate_next = R_IDLE;
        end
      end
      default: rstate_next = R_IDLE;
    endcase

    arready_next = (rstate_next == R_IDLE);
    rvalid_next  = (rstate_next == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_reg  <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= OKAY;
      rdata_reg   <= '0;
    end else begin
      rstate_reg  <= rstate_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rresp_reg   <= rresp_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign bus.awready = awready_reg;
  assign bus.wready  = wready_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = arready_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rdata   = rdata_reg;

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder with an internal register file: the target end of `axi_lite_if`, answering the write/read transactions issued by the bench-side AXI-Lite master. Independent write and read channels, byte strobes, OKAY/SLVERR responses. Sits behind `axi_lite_if` in `tb_top` as the DUT endpoint, and is reusable as a CSR block in RTL.

## Interface
- `ADDR_WIDTH`, 32: address width; matches `addr_t`.
- `DATA_WIDTH`, 32: data width; matches `data_t`; fixed at 32 (4 strobe bits).
- `NUM_REGS`, 16: number of 32-bit registers.
- `BASE_ADDR`, 0: byte address of register 0.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `awaddr` in ADDR_WIDTH: write address. `awvalid` in 1. `awready` out 1.
- `wdata` in DATA_WIDTH: write data. `wstrb` in 4: byte enables. `wvalid` in 1. `wready` out 1.
- `bresp` out 2: write response. `bvalid` out 1. `bready` in 1.
- `araddr` in ADDR_WIDTH: read address. `arvalid` in 1. `arready` out 1.
- `rdata` out DATA_WIDTH: read data. `rresp` out 2: read response. `rvalid` out 1. `rready` in 1.

## Operation
- Decode: `idx = (addr - BASE_ADDR) >> 2`. The access is valid when `addr[1:0] == 0`, `addr >= BASE_ADDR` and `idx < NUM_REGS`. Otherwise it returns SLVERR (2'b10); a write has no effect and a read returns 0. A valid access returns OKAY (2'b00).
- Write FSM:
  - W_IDLE: `awready` = `wready` = 1.
    - AW and W handshake in the same cycle -> W_RESP.
    - AW alone -> W_WAIT_DATA, which holds the address with `awready` = 0.
    - W alone -> W_WAIT_ADDR, which holds data and strobe with `wready` = 0.
  - W_WAIT_DATA / W_WAIT_ADDR: on the missing handshake -> W_RESP.
  - Commit rule: the register update happens on the edge that enters W_RESP. Each byte `b` with `wstrb[b] = 1` is written. `wstrb = 0` is a legal no-op and returns OKAY.
  - W_RESP: `bvalid` = 1 and `bresp` is held stable until `bready` is sampled high -> W_IDLE. Both readies are 0 in this state.
- Read FSM:
  - R_IDLE: `arready` = 1. On an AR handshake, `rdata`/`rresp` are registered from the current register contents -> R_RESP.
  - R_RESP: `rvalid` = 1 and data is held stable until `rready` -> R_IDLE. `arready` = 0 in this state.
- Write and read channels are fully independent and may be active in the same cycle.
- Same-cycle AR handshake and write commit to the same register: the read returns the pre-write value.
- One outstanding transaction per channel. No ID, no burst, no `*prot` decoding.

## Timing
- Reset values, applied while `rst` = 1 on a clock edge: every register 0, both FSMs idle, all `*ready` = 0, `bvalid` = `rvalid` = 0, `bresp` = `rresp` = 0, `rdata` = 0.
- Readies are registered. They rise in the first cycle after `rst` falls.
- Write latency: the AW/W handshakes complete at edge t -> `bvalid` is high from cycle t+1. `bvalid` is never asserted before both handshakes have completed.
- Read latency: AR handshake at edge t -> `rvalid` high from cycle t+1.
- Back-to-back throughput: after a B or R handshake at edge t, the idle readies are high at t+1. Maximum rate is one transaction per 2 cycles per channel.
- A VALID-without-READY wait (`bready` or `rready` low) stalls indefinitely with outputs stable.
- `rst` asserted mid-transaction: the transaction is abandoned. Any write not yet committed is dropped, and the next cycle shows reset values.

## Structure
- `axi_lite_pkg` holds:
  - `addr_t` and `data_t`, already present.
  - New `resp_t` enum: OKAY = 2'b00, SLVERR = 2'b10.
  - The `wfsm_t` and `rfsm_t` state enums.
- Sub-module `axi_lite_addr_decode` is combinational. It maps an address to `idx` plus a `hit` flag and is instantiated twice, once for AW and once for AR.
- Top level: two FSMs plus the register array. Target 200–300 lines.

## Test plan
- Aligned write then read:
  - Write 0xDEADBEEF to 0x04 with `wstrb` = 4'hF -> `bresp` OKAY.
  - Read 0x04 -> `rdata` 0xDEADBEEF, `rresp` OKAY.
- Byte strobes:
  - Write 0xFFFFFFFF, then 0x12345678 with `wstrb` = 4'b0101 to 0x08 -> reading back gives 0xFF34FF78.
- AW/W ordering:
  - W leads AW by 3 cycles -> `wready` drops after W, and `bvalid` is high one cycle after the AW handshake.
  - AW-first variant gives the same final register value.
- Errors:
  - Write to 0x40 (idx 16) -> SLVERR and no register changes.
  - Read 0x06 (misaligned) -> SLVERR with `rdata` 0.
- Backpressure:
  - Hold `bready`/`rready` low for 5 cycles -> `bvalid`/`rvalid` and the payload stay stable, and new AW/AR are not accepted.
- Reset mid-transaction:
  - Assert `rst` after an AW handshake but before W -> all outputs return to reset values.
  - A subsequent read of that address returns 0.
